mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port between instruction fetch (I) and the

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D); one access outstanding at a time.
// Latency: grant and mem_en are combinational in the issue cycle, rvalid MEM_LAT cycles later.
// Backpressure: requesters hold req until gnt; D is capped at STARVE_MAX wins while I waits.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MEM_LAT + 1);
  localparam int STK_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(MEM_LAT);
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(STARVE_MAX);

  typedef enum logic {IDLE, WAIT} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STK_W-1:0]  streak_q, streak_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic slot_free;
  logic complete;
  logic issue;
  logic win_d;

  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;
  assign busy     = (state_q == WAIT);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    streak_d  = streak_q;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_wstrb = '0;

    // The completion cycle doubles as the next issue slot, giving one access per MEM_LAT cycles.
    slot_free = (state_q == IDLE) || (cnt_q == CNT_ONE);
    complete  = (state_q == WAIT) && (cnt_q == CNT_ONE) && !rst;
    issue     = !rst && slot_free && (if_req || d_req);
    win_d     = d_req && !(if_req && (streak_q == STK_MAX));

    if_rvalid = complete && (owner_q == OWN_I);
    d_rvalid  = complete && (owner_q == OWN_D);

    if (issue) begin
      mem_en  = 1'b1;
      state_d = WAIT;
      cnt_d   = CNT_LAT;
      if (win_d) begin
        d_gnt     = 1'b1;
        owner_d   = OWN_D;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wstrb = d_we ? d_wstrb : {STRB_W{1'b0}};
        if (!if_req) begin
          streak_d = '0;
        end else if (streak_q != STK_MAX) begin
          streak_d = streak_q + STK_W'(1);
        end
      end else begin
        if_gnt   = 1'b1;
        owner_d  = OWN_I;
        mem_addr = if_addr;
        streak_d = '0;
      end
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      cnt_q       <= '0;
      streak_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random checks of mem_port_arbiter at MEM_LAT=2 (instance a) and MEM_LAT=1 (instance b).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        if_req_a, if_gnt_a, if_rvalid_a, d_req_a, d_we_a, d_gnt_a, d_rvalid_a;
  logic        mem_en_a, mem_we_a, busy_a;
  logic [31:0] if_addr_a, if_rdata_a, d_addr_a, d_wdata_a, d_rdata_a;
  logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic [3:0]  d_wstrb_a, mem_wstrb_a;

  logic        if_req_b, if_gnt_b, if_rvalid_b, d_req_b, d_we_b, d_gnt_b, d_rvalid_b;
  logic        mem_en_b, mem_we_b, busy_b;
  logic [31:0] if_addr_b, if_rdata_b, d_addr_b, d_wdata_b, d_rdata_b;
  logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [3:0]  d_wstrb_b, mem_wstrb_b;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_gnt(if_gnt_a), .if_rvalid(if_rvalid_a),
    .if_rdata(if_rdata_a), .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a),
    .d_wdata(d_wdata_a), .d_wstrb(d_wstrb_a), .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a),
    .d_rdata(d_rdata_a), .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_wstrb(mem_wstrb_a), .mem_rdata(mem_rdata_a), .busy(busy_a)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b),
    .if_rdata(if_rdata_b), .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b),
    .d_wdata(d_wdata_b), .d_wstrb(d_wstrb_b), .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b),
    .d_rdata(d_rdata_b), .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_wstrb(mem_wstrb_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000 ^ {a[15:0], 16'h0};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory macro models: a is read/write with a 2-stage read pipe, b is read-only with 1 stage.
  logic [31:0] mem_a [logic [31:0]];
  logic [31:0] pipe_a;
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_a.exists(a) ? mem_a[a] : init_word(a);
  endfunction
  always @(posedge clk) begin
    if (mem_en_a) begin
      pipe_a <= mem_rd(mem_addr_a);
      if (mem_we_a) mem_a[mem_addr_a] = merge(mem_rd(mem_addr_a), mem_wdata_a, mem_wstrb_a);
    end
    mem_rdata_a <= pipe_a;
    if (mem_en_b) mem_rdata_b <= init_word(mem_addr_b);
  end

  // Scoreboard for instance a: shadow memory updated at grant, expectations queued at grant.
  typedef struct { logic is_d; logic is_st; logic [31:0] data; int due; } exp_t;
  exp_t exp_q[$];
  logic [31:0] sh_a [logic [31:0]];
  int gnt_cnt = 0, rv_cnt = 0, aborted = 0, d_streak = 0;

  function automatic logic [31:0] sh_rd(input logic [31:0] a);
    return sh_a.exists(a) ? sh_a[a] : init_word(a);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_quiet_a", 64'({if_gnt_a, d_gnt_a, if_rvalid_a, d_rvalid_a, mem_en_a}), 64'(0));
      aborted += exp_q.size();
      exp_q.delete();
      d_streak = 0;
    end else begin
      if (if_rvalid_a || d_rvalid_a) begin
        chk("rv_one", 64'(if_rvalid_a & d_rvalid_a), 64'(0));
        if (exp_q.size() == 0) begin
          chk("rv_unexpected", 64'({if_rvalid_a, d_rvalid_a}), 64'(0));
        end else begin
          e = exp_q.pop_front();
          rv_cnt++;
          chk("rv_owner", 64'(d_rvalid_a), 64'(e.is_d));
          chk("rv_latency", 64'(cyc), 64'(e.due));
          if (!e.is_st) chk("rv_data", 64'(e.is_d ? d_rdata_a : if_rdata_a), 64'(e.data));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        chk("rv_missing", 64'({if_rvalid_a, d_rvalid_a}), 64'(exp_q[0].is_d ? 1 : 2));
        void'(exp_q.pop_front());
      end
      if (if_gnt_a || d_gnt_a) chk("one_gnt", 64'(if_gnt_a & d_gnt_a), 64'(0));
      if (if_gnt_a) begin
        chk("if_gnt_req", 64'(if_req_a), 64'(1));
        chk("if_mem", 64'({mem_en_a, mem_we_a, mem_wstrb_a, mem_addr_a}),
            64'({1'b1, 1'b0, 4'h0, if_addr_a}));
        exp_q.push_back('{1'b0, 1'b0, sh_rd(if_addr_a), cyc + 2});
        gnt_cnt++;
        d_streak = 0;
      end
      if (d_gnt_a) begin
        chk("d_gnt_req", 64'(d_req_a), 64'(1));
        chk("d_mem", 64'({mem_en_a, mem_we_a, mem_wstrb_a, mem_addr_a}),
            64'({1'b1, d_we_a, d_we_a ? d_wstrb_a : 4'h0, d_addr_a}));
        if (d_we_a) begin
          chk("d_wdata", 64'(mem_wdata_a), 64'(d_wdata_a));
          sh_a[d_addr_a] = merge(sh_rd(d_addr_a), d_wdata_a, d_wstrb_a);
        end
        exp_q.push_back('{1'b1, d_we_a, sh_rd(d_addr_a), cyc + 2});
        gnt_cnt++;
        if (if_req_a) begin
          d_streak++;
          chk("starve", 64'(d_streak <= 4), 64'(1));
        end else begin
          d_streak = 0;
        end
      end
      if (!if_gnt_a && !d_gnt_a) chk("idle_mem", 64'({mem_en_a, mem_we_a, mem_wstrb_a}), 64'(0));
    end
  end

  task automatic d_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    d_req_a = 1'b1; d_we_a = we; d_addr_a = a; d_wdata_a = wd; d_wstrb_a = st;
    n = 0;
    @(negedge clk);
    while (!d_gnt_a && n < 10) begin @(negedge clk); n++; end
    chk("dtxn_gnt", 64'(d_gnt_a), 64'(1));
    @(posedge clk); #1;
    d_req_a = 1'b0; d_we_a = 1'b0;
    n = 0;
    @(negedge clk);
    while (!d_rvalid_a && n < 10) begin @(negedge clk); n++; end
    chk("dtxn_rvalid", 64'(d_rvalid_a), 64'(1));
    rd = d_rdata_a;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, cur, exp_w;
    logic        gi, gd;
    int          n, last, wi, wd;
    logic [31:0] exp_b[$];

    rst = 1'b1;
    if_req_a = 0; if_addr_a = 0; d_req_a = 0; d_we_a = 0; d_addr_a = 0; d_wdata_a = 0; d_wstrb_a = 0;
    if_req_b = 0; if_addr_b = 0; d_req_b = 0; d_we_b = 0; d_addr_b = 0; d_wdata_b = 0; d_wstrb_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl_a", 64'({if_gnt_a, d_gnt_a, if_rvalid_a, d_rvalid_a, mem_en_a, mem_we_a, busy_a}), 64'(0));
    chk("reset_mem_a", 64'({mem_addr_a, mem_wdata_a}), 64'(0));
    chk("reset_strb_a", 64'(mem_wstrb_a), 64'(0));
    chk("reset_ctl_b", 64'({d_gnt_b, d_rvalid_b, mem_en_b, busy_b, mem_addr_b}), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Lone fetch.
    if_req_a = 1'b1; if_addr_a = 32'h100;
    @(negedge clk);
    chk("t1_gnt", 64'({if_gnt_a, mem_en_a, mem_addr_a}), 64'({2'b11, 32'h100}));
    @(posedge clk); #1 if_req_a = 1'b0;
    @(negedge clk);
    chk("t1_busy1", 64'({busy_a, if_rvalid_a}), 64'(2'b10));
    @(negedge clk);
    chk("t1_busy2", 64'({busy_a, if_rvalid_a}), 64'(2'b11));
    chk("t1_data", 64'(if_rdata_a), 64'(init_word(32'h100)));
    @(negedge clk);
    chk("t1_idle", 64'(busy_a), 64'(0));

    // Store and fetch contend; store wins, fetch issues in the completion cycle.
    @(posedge clk); #1;
    d_req_a = 1; d_we_a = 1; d_addr_a = 32'h200; d_wdata_a = 32'hDEADBEEF; d_wstrb_a = 4'hF;
    if_req_a = 1; if_addr_a = 32'h104;
    @(negedge clk);
    chk("t2_dgnt", 64'({d_gnt_a, if_gnt_a, mem_we_a, mem_wstrb_a}), 64'({3'b101, 4'hF}));
    chk("t2_wdata", 64'(mem_wdata_a), 64'(32'hDEADBEEF));
    @(posedge clk); #1 d_req_a = 0; d_we_a = 0;
    @(negedge clk);
    chk("t2_wait", 64'({if_gnt_a, d_rvalid_a}), 64'(0));
    @(negedge clk);
    chk("t2_complete", 64'({d_rvalid_a, if_gnt_a, mem_addr_a}), 64'({2'b11, 32'h104}));
    @(posedge clk); #1 if_req_a = 0;
    repeat (2) @(negedge clk);
    chk("t2_if_rvalid", 64'(if_rvalid_a), 64'(1));

    d_txn(1'b0, 32'h200, 32'h0, 4'h0, rd);
    chk("t2_load_back", 64'(rd), 64'(32'hDEADBEEF));
    d_txn(1'b1, 32'h200, 32'h11223344, 4'b0101, rd);
    d_txn(1'b0, 32'h200, 32'h0, 4'h0, rd);
    chk("t2_partial", 64'(rd), 64'(32'hDE22BE44));
    repeat (2) @(negedge clk);

    // Continuous contention: D,D,D,D,I repeating, one issue every 2 cycles.
    @(posedge clk); #1;
    d_req_a = 1; d_we_a = 0; d_addr_a = 32'h20; if_req_a = 1; if_addr_a = 32'h24;
    last = 0;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      @(negedge clk);
      while (!(if_gnt_a || d_gnt_a) && n < 6) begin @(negedge clk); n++; end
      chk("t3_winner", 64'({if_gnt_a, d_gnt_a}), 64'((k % 5 == 4) ? 2 : 1));
      if (k > 0) chk("t3_gap", 64'(cyc - last), 64'(2));
      last = cyc;
    end
    @(posedge clk); #1 d_req_a = 0; if_req_a = 0;
    repeat (4) @(negedge clk);

    // Reset aborts a granted load; a fetch is granted right after reset drops.
    @(posedge clk); #1 d_req_a = 1; d_we_a = 0; d_addr_a = 32'h300;
    @(negedge clk);
    chk("t4_dgnt", 64'(d_gnt_a), 64'(1));
    @(posedge clk); #1 d_req_a = 0; rst = 1;
    @(negedge clk);
    chk("t4_in_rst", 64'({d_rvalid_a, d_gnt_a, if_gnt_a}), 64'(0));
    @(posedge clk); #1 rst = 0; if_req_a = 1; if_addr_a = 32'h400;
    @(negedge clk);
    chk("t4_after", 64'({busy_a, d_rvalid_a, mem_we_a, if_gnt_a, mem_addr_a}), 64'({4'b0001, 32'h400}));
    @(posedge clk); #1 if_req_a = 0;
    repeat (3) @(negedge clk);

    // MEM_LAT=1: back-to-back loads alternating between two addresses.
    @(posedge clk); #1 d_req_b = 1; cur = 32'h10; d_addr_b = cur;
    for (int k = 0; k < 8; k++) begin
      exp_b.push_back(init_word(cur));
      @(negedge clk);
      chk("b_gnt", 64'({d_gnt_b, mem_addr_b}), 64'({1'b1, cur}));
      if (k == 0) chk("b_rv_first", 64'(d_rvalid_b), 64'(0));
      else begin
        exp_w = exp_b.pop_front();
        chk("b_rv", 64'(d_rvalid_b), 64'(1));
        chk("b_data", 64'(d_rdata_b), 64'(exp_w));
      end
      @(posedge clk); #1;
      cur = (k % 2 == 0) ? 32'h14 : 32'h10;
      d_addr_b = cur;
      if (k == 7) d_req_b = 0;
    end
    @(negedge clk);
    exp_w = exp_b.pop_front();
    chk("b_rv_last", 64'({d_rvalid_b, d_gnt_b}), 64'(2'b10));
    chk("b_data_last", 64'(d_rdata_b), 64'(exp_w));

    // Random traffic with occasional withdrawals.
    wi = 0; wd = 0;
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      gi = if_gnt_a; gd = d_gnt_a;
      if (if_req_a) begin
        if (gi) begin chk("rnd_wait_i", 64'(wi <= 10), 64'(1)); wi = 0; end else wi++;
      end
      if (d_req_a) begin
        if (gd) begin chk("rnd_wait_d", 64'(wd <= 4), 64'(1)); wd = 0; end else wd++;
      end
      @(posedge clk); #1;
      if (gi || !if_req_a) begin
        if_req_a = ($urandom_range(0, 3) != 0);
        if_addr_a = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      end else if ($urandom_range(0, 15) == 0) begin
        if_req_a = 0; wi = 0;
      end
      if (gd || !d_req_a) begin
        d_req_a = ($urandom_range(0, 3) != 0);
        d_we_a = $urandom_range(0, 1) == 1;
        d_addr_a = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
        d_wdata_a = $urandom;
        d_wstrb_a = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) begin
        d_req_a = 0; wd = 0;
      end
    end
    for (int k = 0; k < 40 && (if_req_a || d_req_a); k++) begin
      @(negedge clk);
      gi = if_gnt_a; gd = d_gnt_a;
      @(posedge clk); #1;
      if (gi) if_req_a = 0;
      if (gd) d_req_a = 0;
    end
    chk("rnd_drain", 64'({if_req_a, d_req_a}), 64'(0));
    repeat (6) @(negedge clk);
    chk("rnd_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("rnd_rv_count", 64'(rv_cnt), 64'(gnt_cnt - aborted));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
